// File: rtl/sramlike_bram_slave.sv
// sram_like bus responder backed by a single-port synchronous BRAM.
// One outstanding transaction; response delayed by a configurable number of cycles.
module sramlike_bram_slave #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DELAY  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(DELAY + 1);

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic              first_q;
    logic              wr_q;
    logic              ram_en_q;
    logic [3:0]        ram_wen_q;
    logic              data_ok_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic [3:0]        strb_d;

    // Address bits above the BRAM depth alias; addr[0] never affects the strobe.
    logic unused_addr;
    assign unused_addr = ^{addr[31:ADDR_W+2], addr[0]};

    always_comb begin
        strb_d = 4'b1111;
        case (size)
            2'd0:    strb_d = 4'b0001 << addr[1:0];
            2'd1:    strb_d = addr[1] ? 4'b1100 : 4'b0011;
            default: strb_d = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            wr_q        <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_wen_q   <= '0;
            data_ok_q   <= 1'b0;
            rdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_en_q  <= 1'b0;
            ram_wen_q <= '0;
            data_ok_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        wr_q        <= wr;
                        ram_addr_q  <= addr[ADDR_W+1:2];
                        ram_wdata_q <= wdata;
                        cnt_q       <= CNT_INIT;
                        first_q     <= 1'b1;
                        ram_en_q    <= 1'b1;
                        ram_wen_q   <= wr ? strb_d : 4'b0000;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    first_q <= 1'b0;
                    if (!first_q) begin
                        // Counter still at its load value marks the second WAIT cycle.
                        if (cnt_q == CNT_INIT && !wr_q) begin
                            rdata_q <= ram_rdata;
                        end
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_q   <= RESP;
                            data_ok_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign addr_ok   = (state_q == IDLE) & ~rst;
    assign data_ok   = data_ok_q & ~rst;
    assign ram_en    = ram_en_q & ~rst;
    assign ram_wen   = rst ? 4'b0000 : ram_wen_q;
    assign rdata     = rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_sramlike_bram_slave.sv
// Bench: two responders (DELAY=0/ADDR_W=14 and DELAY=5/ADDR_W=4) with behavioural BRAMs,
// checked against a byte-lane memory model, fixed vectors and reset corner sequences.
module tb_sramlike_bram_slave;

    localparam int unsigned AW0 = 14;
    localparam int unsigned AW1 = 4;
    localparam int unsigned D0  = 0;
    localparam int unsigned D1  = 5;

    logic        clk;
    logic        rst;
    logic        req_s   [2];
    logic        wr_s;
    logic [1:0]  size_s;
    logic [31:0] addr_s;
    logic [31:0] wdata_s;
    logic [31:0] rdata_o [2];
    logic        aok     [2];
    logic        dok     [2];
    logic        ren     [2];
    logic [3:0]  rwen    [2];
    logic [31:0] rwd     [2];
    logic [31:0] rrd     [2];
    logic [31:0] rax     [2];
    logic [AW0-1:0] ra0;
    logic [AW1-1:0] ra1;

    assign rax[0] = 32'(ra0);
    assign rax[1] = 32'(ra1);

    sramlike_bram_slave #(.ADDR_W(AW0), .DELAY(D0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req_s[0]), .wr(wr_s), .size(size_s), .addr(addr_s),
        .wdata(wdata_s), .rdata(rdata_o[0]), .addr_ok(aok[0]), .data_ok(dok[0]),
        .ram_en(ren[0]), .ram_wen(rwen[0]), .ram_addr(ra0), .ram_wdata(rwd[0]),
        .ram_rdata(rrd[0])
    );

    sramlike_bram_slave #(.ADDR_W(AW1), .DELAY(D1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req_s[1]), .wr(wr_s), .size(size_s), .addr(addr_s),
        .wdata(wdata_s), .rdata(rdata_o[1]), .addr_ok(aok[1]), .data_ok(dok[1]),
        .ram_en(ren[1]), .ram_wen(rwen[1]), .ram_addr(ra1), .ram_wdata(rwd[1]),
        .ram_rdata(rrd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port BRAMs, read data valid the cycle after enable.
    logic [31:0] mem0 [1 << AW0];
    logic [31:0] mem1 [1 << AW1];
    logic [31:0] t0, t1;

    initial begin
        for (int i = 0; i < (1 << AW0); i++) mem0[i] = '0;
        for (int i = 0; i < (1 << AW1); i++) mem1[i] = '0;
    end

    always @(posedge clk) begin
        if (ren[0]) begin
            t0 = mem0[ra0];
            for (int b = 0; b < 4; b++) if (rwen[0][b]) t0[8*b +: 8] = rwd[0][8*b +: 8];
            mem0[ra0] <= t0;
            rrd[0]    <= mem0[ra0];
        end
        if (ren[1]) begin
            t1 = mem1[ra1];
            for (int b = 0; b < 4; b++) if (rwen[1][b]) t1[8*b +: 8] = rwd[1][8*b +: 8];
            mem1[ra1] <= t1;
            rrd[1]    <= mem1[ra1];
        end
    end

    int n_chk;
    int n_fail;
    logic [31:0] mdl [int unsigned];
    logic [31:0] last_rd [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One transaction on unit u, entered just after a negedge; leaves at the negedge of
    // the first IDLE cycle after RESP.
    task automatic txn(input int u, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] got_rd, output logic [3:0] got_wen,
                       output logic [31:0] got_addr);
        int unsigned d    = (u == 0) ? D0 : D1;
        int unsigned aw   = (u == 0) ? AW0 : AW1;
        int unsigned span = 32'd4 << aw;
        int unsigned widx = (a % span) / 4;
        int unsigned key  = u * 32'h10000 + widx;
        int unsigned nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        int unsigned lo   = (int'(a[1:0]) / nb) * nb;
        logic [3:0]  ew   = 4'(((1 << nb) - 1) << lo);
        logic [31:0] word = mdl.exists(key) ? mdl[key] : 32'h0;
        logic [31:0] er;
        int n = 0;
        got_rd = 'x; got_wen = 'x; got_addr = 'x;
        req_s[u] = 1'b1; wr_s = w; size_s = sz; addr_s = a; wdata_s = wd;
        while (!aok[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!aok[u]) begin
            chk("accept_timeout", 32'(aok[u]), 32'd1);
            req_s[u] = 1'b0;
            return;
        end
        if (w) begin
            for (int b = 0; b < 4; b++) if (ew[b]) word[8*b +: 8] = wd[8*b +: 8];
            mdl[key] = word;
            er = last_rd[u];
        end else begin
            er = word;
            last_rd[u] = word;
        end
        for (int unsigned k = 1; k <= 3 + d; k++) begin
            @(negedge clk);
            chk("addr_ok_busy", 32'(aok[u]), 32'd0);
            chk("ram_en", 32'(ren[u]), 32'(k == 1));
            chk("ram_wen", 32'(rwen[u]), (k == 1 && w) ? 32'(ew) : 32'd0);
            chk("data_ok", 32'(dok[u]), 32'(k == 3 + d));
            if (k == 1) begin
                got_wen  = rwen[u];
                got_addr = rax[u];
                chk("ram_addr", rax[u], widx);
                chk("ram_wdata", rwd[u], wd);
            end
            if (k == 3 + d) begin
                got_rd = rdata_o[u];
                chk("rdata", rdata_o[u], er);
                req_s[u] = 1'b0;
            end
        end
        @(negedge clk);
        chk("addr_ok_back", 32'(aok[u]), 32'd1);
        chk("data_ok_pulse", 32'(dok[u]), 32'd0);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  ew;
        logic [31:0] ea;
        logic [31:0] er;
    } vec_t;

    vec_t tbl [10];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] g_rd, g_addr;
        logic [3:0]  g_wen;
        n_chk = 0; n_fail = 0;
        rst = 1'b1; req_s[0] = 1'b0; req_s[1] = 1'b0;
        wr_s = 1'b0; size_s = 2'd0; addr_s = '0; wdata_s = '0;
        last_rd[0] = '0; last_rd[1] = '0;

        tbl[0] = '{1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 4'hF, 32'd4, 32'h0};
        tbl[1] = '{1'b0, 2'd2, 32'h10, 32'h0,        4'h0, 32'd4, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 2'd1, 32'h12, 32'h12340000, 4'hC, 32'd4, 32'hDEADBEEF};
        tbl[3] = '{1'b1, 2'd0, 32'h13, 32'hAA000000, 4'h8, 32'd4, 32'hDEADBEEF};
        tbl[4] = '{1'b1, 2'd0, 32'h10, 32'h00000077, 4'h1, 32'd4, 32'hDEADBEEF};
        tbl[5] = '{1'b0, 2'd2, 32'h10, 32'h0,        4'h0, 32'd4, 32'hAA34BE77};
        tbl[6] = '{1'b1, 2'd1, 32'h11, 32'h0000CAFE, 4'h3, 32'd4, 32'hAA34BE77};
        tbl[7] = '{1'b0, 2'd2, 32'h10, 32'h0,        4'h0, 32'd4, 32'hAA34CAFE};
        tbl[8] = '{1'b1, 2'd3, 32'h20, 32'h01020304, 4'hF, 32'd8, 32'hAA34CAFE};
        tbl[9] = '{1'b0, 2'd2, 32'h20, 32'h0,        4'h0, 32'd8, 32'h01020304};

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr_ok", 32'(aok[0]), 32'd0);
        chk("rst_data_ok", 32'(dok[0]), 32'd0);
        chk("rst_rdata", rdata_o[0], 32'd0);
        chk("rst_ram_en", 32'(ren[0]), 32'd0);
        chk("rst_ram_wen", 32'(rwen[0]), 32'd0);
        chk("rst_ram_addr", rax[0], 32'd0);
        chk("rst_ram_wdata", rwd[0], 32'd0);
        chk("rst_addr_ok1", 32'(aok[1]), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_addr_ok", 32'(aok[0]), 32'd1);
        chk("rel_data_ok", 32'(dok[0]), 32'd0);
        chk("rel_addr_ok1", 32'(aok[1]), 32'd1);

        // Fixed vectors, DELAY=0
        for (int i = 0; i < 10; i++) begin
            txn(0, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, g_rd, g_wen, g_addr);
            chk($sformatf("vec%0d_wen", i), 32'(g_wen), 32'(tbl[i].ew));
            chk($sformatf("vec%0d_addr", i), g_addr, tbl[i].ea);
            chk($sformatf("vec%0d_rdata", i), g_rd, tbl[i].er);
        end

        // DELAY=5, ADDR_W=4: aliasing plus held request
        txn(1, 1'b1, 2'd2, 32'h40, 32'h11223344, g_rd, g_wen, g_addr);
        chk("alias_wr_addr", g_addr, 32'd0);
        txn(1, 1'b0, 2'd2, 32'h0, 32'h0, g_rd, g_wen, g_addr);
        chk("alias_rd_data", g_rd, 32'h11223344);
        for (int i = 0; i < 30; i++)
            txn(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                g_rd, g_wen, g_addr);

        // Randomised traffic on the DELAY=0 unit
        for (int i = 0; i < 40; i++)
            txn(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                32'($urandom_range(0, 255)), $urandom, g_rd, g_wen, g_addr);

        // Reset during the second WAIT cycle of a read
        req_s[0] = 1'b1; wr_s = 1'b0; size_s = 2'd2; addr_s = 32'h10;
        @(posedge clk); #1 req_s[0] = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_addr_ok", 32'(aok[0]), 32'd0);
        chk("mid_rst_data_ok", 32'(dok[0]), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_no_data_ok", 32'(dok[0]), 32'd0);
            chk("mid_rst_rdata", rdata_o[0], 32'd0);
            chk("mid_rst_addr_ok_back", 32'(aok[0]), 32'd1);
        end
        last_rd[0] = '0; last_rd[1] = '0;
        txn(0, 1'b0, 2'd2, 32'h10, 32'h0, g_rd, g_wen, g_addr);

        // Reset coinciding with a write's BRAM-enable cycle suppresses the write
        req_s[0] = 1'b1; wr_s = 1'b1; size_s = 2'd2; addr_s = 32'h30; wdata_s = 32'hFFFFFFFF;
        @(posedge clk); #1 req_s[0] = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("sup_ram_en", 32'(ren[0]), 32'd0);
        chk("sup_ram_wen", 32'(rwen[0]), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("sup_addr_ok", 32'(aok[0]), 32'd1);
        last_rd[0] = '0; last_rd[1] = '0;
        txn(0, 1'b0, 2'd2, 32'h30, 32'h0, g_rd, g_wen, g_addr);
        txn(1, 1'b0, 2'd2, 32'h0, 32'h0, g_rd, g_wen, g_addr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sramlike_bram_slave.md
# sramlike_bram_slave

Responder end of the sram_like bus. Accepts one request at a time from an sram_like master (the instruction- or data-side bridge), performs the read or write on a single-port synchronous block RAM, and answers with `data_ok`. It lets CPU-side bridges be exercised against local memory, with a configurable extra response delay so the master's stall paths are covered.

## Interface
Parameters:
- `ADDR_W`, 14: BRAM word-address width. Depth is 2^ADDR_W 32-bit words.
- `DELAY`, 0: extra wait cycles added before `data_ok`. Legal range is 0..254.

Ports:
- `clk` in 1: single clock. Everything is on the rising edge.
- `rst` in 1: reset. It is synchronous and active-high.
- `req` in 1: master request valid.
- `wr` in 1: 1 means write, 0 means read.
- `size` in 2: 0 is byte, 1 is halfword, 2 is word, 3 is treated as word.
- `addr` in 32: byte address.
- `wdata` in 32: write data. The master has already placed it in the correct byte lanes.
- `rdata` out 32: read data. It is valid while `data_ok` is high.
- `addr_ok` out 1: request accepted.
- `data_ok` out 1: transaction complete. It is a one-cycle pulse.
- `ram_en` out 1: BRAM enable.
- `ram_wen` out 4: BRAM byte write enables.
- `ram_addr` out ADDR_W: BRAM word address.
- `ram_wdata` out 32: BRAM write data.
- `ram_rdata` in 32: BRAM read data. It is valid in the cycle after `ram_en`.

## Operation
- State machine with three states: IDLE, WAIT, RESP. Reset value is IDLE.
- **IDLE**
  - `addr_ok` = ~`rst`. It is decoded from the state with no dependence on `req`.
  - Handshake (`req` & `addr_ok`): latch `wr`, `addr`, `wdata`, and the computed byte strobe.
  - Load the counter with 1+DELAY, set the `first` flag, and go to WAIT.
  - No handshake: stay in IDLE.
- **WAIT**
  - `addr_ok`=0. Any `req` is ignored and is neither latched nor lost: the master holds it.
  - First WAIT cycle (`first`=1): `ram_en`=1. `ram_wen` = strobe if `wr`, else 0. `first` clears.
  - Later WAIT cycles: `ram_en`=0, `ram_wen`=0.
  - On read, capture `ram_rdata` into `rdata_q` at the end of the second WAIT cycle.
  - The counter decrements each WAIT cycle after the first. When it reaches 0 and `first`=0, go to RESP.
  - WAIT lasts exactly 2+DELAY cycles.
- **RESP**
  - `data_ok`=1 for exactly one cycle. `rdata` = `rdata_q`. Go to IDLE.
- Byte strobe, computed from `size` and `addr[1:0]`:
  - size 0: 4'b0001 << `addr[1:0]`.
  - size 1: `addr[1]` ? 4'b1100 : 4'b0011.
  - size 2 or 3: 4'b1111.
  - Misaligned halfword (`addr[0]`=1) uses the same rule. There is no exception; `addr[0]` is ignored.
- Address mapping:
  - `ram_addr` = latched `addr[ADDR_W+1:2]`. Upper bits are ignored, so addresses wrap (alias) modulo 4·2^ADDR_W bytes.
  - `ram_wdata` = latched `wdata`.
- Reads always return the full word. The master extracts the bytes it needs.
- `rdata` / `rdata_q` keeps its value across writes and idle cycles. It changes only on a read capture or reset.
- `ram_addr` and `ram_wdata` hold their latched values until the next acceptance.

## Timing
- Handshake accepted at cycle T:
  - `ram_en` at T+1.
  - `ram_rdata` sampled at the end of T+2.
  - `data_ok` at T+3+DELAY.
  - `addr_ok` again at T+4+DELAY.
- Back-to-back throughput is one transaction per 4+DELAY cycles. At most one transaction is outstanding.
- Write latency equals read latency. BRAM contents update at the end of T+1.
- `data_ok` never coincides with `addr_ok`, so the master's "addr_ok & data_ok same cycle" case never arises from this block.
- Reset values: state IDLE, `addr_ok`=0 while `rst`=1, `data_ok`=0, `rdata`=0, `ram_en`=0, `ram_wen`=0, `ram_addr`=0, `ram_wdata`=0, counter 0, `first` 0.
- Reset in any state aborts the transaction:
  - The pending `data_ok` is never issued.
  - A write whose `ram_en` cycle coincides with `rst` is suppressed (`ram_en`/`ram_wen` are forced to 0 while `rst`=1).
  - `addr_ok` returns in the first cycle after `rst` deasserts.
- `req` dropped before acceptance has no effect. `req` held through RESP is accepted in the following IDLE cycle.

## Test plan
- **Reset check:** hold `rst` for 3 cycles → all outputs 0, including `addr_ok`. First cycle after release → `addr_ok`=1, `data_ok`=0.
- **Word write then read, DELAY=0:** write word 0xDEADBEEF at addr 0x10, then read addr 0x10 → `ram_wen`=4'b1111 and `ram_addr`=4. Read `data_ok` arrives 3 cycles after `addr_ok` with `rdata`=0xDEADBEEF.
- **Sub-word writes:**
  - byte write, addr 0x13, wdata 0xAA000000 → `ram_wen`=4'b1000.
  - halfword write, addr 0x12 → `ram_wen`=4'b1100.
  - read 0x10 afterwards → merged word is correct.
- **Extra delay:** DELAY=5, read → `data_ok` at T+8, next `addr_ok` at T+9. `req` held continuously is ignored during WAIT and RESP, and accepted exactly once per transaction.
- **Reset mid-op:** assert `rst` in the second WAIT cycle of a read → no `data_ok`, `rdata`=0. Next transaction completes with normal latency.
- **Aliasing:** ADDR_W=4, write 0x11223344 at addr 0x40 → it lands at word 0. Reading addr 0x0 returns 0x11223344.
